// File: rtl/maze_pkg.sv
// ---------------------------------------------------------------------------
// maze_pkg
// Shared types and constants for the maze game-logic stage.
//   maze_state_t : controller FSM states
//   dir_t        : decoded button direction (one at a time, by priority)
//   MAZE_COLS/MAZE_ROWS : playfield size in blocks
//   ROM_ROW_SHIFT: the maze ROM stores 64 words per row
//   WALL_MASK    : colour bits of a ROM word; any set bit marks a wall
// ---------------------------------------------------------------------------
package maze_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CHECK,
    ST_COOLDOWN,
    ST_WIN
  } maze_state_t;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  localparam int          MAZE_COLS     = 40;
  localparam int          MAZE_ROWS     = 30;
  localparam int          ROM_ROW_SHIFT = 6;
  localparam logic [11:0] WALL_MASK     = 12'hFFF;

  // ROM word address of a block: col + (row << 6).
  function automatic logic [10:0] block_addr(input logic [5:0] col,
                                             input logic [5:0] row);
    return 11'(col) + (11'(row) << ROM_ROW_SHIFT);
  endfunction

endpackage

// File: rtl/maze_controller.sv
// ---------------------------------------------------------------------------
// maze_controller
// Game-logic stage ahead of the frame renderer. Turns held direction buttons
// into one-block moves, checks each target block against the shared maze ROM,
// rate-limits attempts with a cooldown counter and flags a win on the exit.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   i_up/i_down/i_left/i_right        debounced, level-sensitive buttons
//   i_restart                         1-cycle pulse: back to start, FSM IDLE
//   o_rom_en, o_rom_addr[10:0]        maze ROM read port (data next cycle)
//   i_rom_data[15:0]                  maze ROM word
//   o_player_bcol/o_player_brow[5:0]  player block position
//   o_exit_bcol/o_exit_brow[5:0]      fixed exit block
//   o_win                             high while in the WIN state
//   o_moves[9:0]                      successful-move count (saturating),
//                                     present only with MAZE_MOVE_COUNT_EN
//
// Build option: define MAZE_MOVE_COUNT_EN to add the o_moves counter.
// ---------------------------------------------------------------------------
module maze_controller
  import maze_pkg::*;
#(
  parameter int MOVE_TICKS = 25_000_000,
  parameter int START_BCOL = 1,
  parameter int START_BROW = 1,
  parameter int EXIT_BCOL  = 38,
  parameter int EXIT_BROW  = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_up,
  input  logic        i_down,
  input  logic        i_left,
  input  logic        i_right,
  input  logic        i_restart,
  output logic        o_rom_en,
  output logic [10:0] o_rom_addr,
  input  logic [15:0] i_rom_data,
  output logic [5:0]  o_player_bcol,
  output logic [5:0]  o_player_brow,
  output logic [5:0]  o_exit_bcol,
  output logic [5:0]  o_exit_brow,
  output logic        o_win
`ifdef MAZE_MOVE_COUNT_EN
  ,
  output logic [9:0]  o_moves
`endif
);

  localparam int                CNT_W    = $clog2(MOVE_TICKS);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MOVE_TICKS - 1);
  localparam logic [5:0]        START_C  = 6'(START_BCOL);
  localparam logic [5:0]        START_R  = 6'(START_BROW);
  localparam logic [5:0]        EXIT_C   = 6'(EXIT_BCOL);
  localparam logic [5:0]        EXIT_R   = 6'(EXIT_BROW);

  maze_state_t      state_q, state_d;
  logic [5:0]       pcol_q, pcol_d, prow_q, prow_d;
  logic [5:0]       tcol_q, tcol_d, trow_q, trow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rom_en_q;
  logic [10:0]      rom_addr_q;
  logic             win_q;

  dir_t             dir;
  logic             off_field;
  logic [5:0]       ncol, nrow;
  logic             is_wall;
  logic             at_exit;

  // Bits above the colour field carry no wall information.
  logic             unused_rom_hi;
  assign unused_rom_hi = ^i_rom_data[15:12];

  assign is_wall = (i_rom_data[11:0] & WALL_MASK) != 12'h000;
  assign at_exit = (pcol_q == EXIT_C) && (prow_q == EXIT_R);

  // Single direction by priority up > down > left > right, and its target.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    dir       = DIR_NONE;
    off_field = 1'b0;
    ncol      = pcol_q;
    nrow      = prow_q;
    if      (i_up)    dir = DIR_UP;
    else if (i_down)  dir = DIR_DOWN;
    else if (i_left)  dir = DIR_LEFT;
    else if (i_right) dir = DIR_RIGHT;

    case (dir)
      DIR_UP: begin
        off_field = (prow_q == 6'd0);
        nrow      = prow_q - 6'd1;
      end
      DIR_DOWN: begin
        off_field = (prow_q == 6'(MAZE_ROWS - 1));
        nrow      = prow_q + 6'd1;
      end
      DIR_LEFT: begin
        off_field = (pcol_q == 6'd0);
        ncol      = pcol_q - 6'd1;
      end
      DIR_RIGHT: begin
        off_field = (pcol_q == 6'(MAZE_COLS - 1));
        ncol      = pcol_q + 6'd1;
      end
      default: ;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    pcol_d  = pcol_q;
    prow_d  = prow_q;
    tcol_d  = tcol_q;
    trow_d  = trow_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (dir != DIR_NONE) begin
          if (off_field) begin
            // Off-field attempts skip the ROM but still pay the cooldown.
            cnt_d   = CNT_LOAD;
            state_d = ST_COOLDOWN;
          end else begin
            // Target frozen here; later button changes cannot alter it.
            tcol_d  = ncol;
            trow_d  = nrow;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: state_d = ST_CHECK;
      ST_CHECK: begin
        if (!is_wall) begin
          pcol_d = tcol_q;
          prow_d = trow_q;
        end
        cnt_d   = CNT_LOAD;
        state_d = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (cnt_q == '0) state_d = at_exit ? ST_WIN : ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_WIN:  ;
      default: state_d = ST_IDLE;
    endcase

    if (i_restart) begin
      state_d = ST_IDLE;
      pcol_d  = START_C;
      prow_d  = START_R;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q    <= ST_IDLE;
      pcol_q     <= START_C;
      prow_q     <= START_R;
      tcol_q     <= '0;
      trow_q     <= '0;
      cnt_q      <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      win_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcol_q   <= pcol_d;
      prow_q   <= prow_d;
      tcol_q   <= tcol_d;
      trow_q   <= trow_d;
      cnt_q    <= cnt_d;
      // ROM port is registered: enable is high exactly during FETCH.
      rom_en_q <= (state_d == ST_FETCH);
      if (state_d == ST_FETCH) rom_addr_q <= block_addr(tcol_d, trow_d);
      win_q    <= (state_d == ST_WIN);
    end
  end

`ifdef MAZE_MOVE_COUNT_EN
  logic [9:0] moves_q, moves_d;

  always_comb begin
    moves_d = moves_q;
    if (state_q == ST_CHECK && !is_wall && moves_q != 10'h3FF)
      moves_d = moves_q + 10'd1;
    if (i_restart) moves_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) moves_q <= '0;
    else     moves_q <= moves_d;
  end

  assign o_moves = moves_q;
`endif

  assign o_rom_en      = rom_en_q;
  assign o_rom_addr    = rom_addr_q;
  assign o_player_bcol = pcol_q;
  assign o_player_brow = prow_q;
  assign o_exit_bcol   = EXIT_C;
  assign o_exit_brow   = EXIT_R;
  assign o_win         = win_q;

endmodule
